// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage of the five-stage pipelined MIPS core.
//               Holds the PC, drives the word address of the combinational
//               program memory and registers the fetched instruction and its
//               PC+4 into the IF/ID boundary. Accepts redirects from MEM and
//               stalls from the hazard unit; inserts NOP bubbles whenever the
//               fetched word must not execute.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEMORY_DEPTH   program memory depth in 32-bit words
//   PC_RESET       PC after reset and byte base address of program memory
// Ports
//   clk            pipeline clock, rising edge
//   reset          asynchronous active-low reset
//   Stall          hold PC and IF/ID registers
//   Redirect       taken branch / jump / jr resolved in MEM
//   RedirectTarget new PC, valid with Redirect
//   IMemAddr       word address into program memory (combinational from PC)
//   IMemData       instruction word for IMemAddr
//   PC             current fetch PC
//   ID_Instruction registered instruction for decode
//   ID_PC_4        registered PC+4 of that instruction
//   ID_Valid       1 = real instruction, 0 = bubble
//   Flush          combinational copy of Redirect (squash ID/EX, EX/MEM)
//   FetchFault     sticky misaligned / out-of-range fetch flag
// ============================================================================
module if_fetch_stage #(
   parameter int          MEMORY_DEPTH = 512,
   parameter logic [31:0] PC_RESET     = 32'h0040_0000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            Stall,
   input  logic                            Redirect,
   input  logic [31:0]                     RedirectTarget,
   output logic [$clog2(MEMORY_DEPTH)-1:0] IMemAddr,
   input  logic [31:0]                     IMemData,
   output logic [31:0]                     PC,
   output logic [31:0]                     ID_Instruction,
   output logic [31:0]                     ID_PC_4,
   output logic                            ID_Valid,
   output logic                            Flush,
   output logic                            FetchFault
);

   localparam int          AW    = $clog2(MEMORY_DEPTH);
   localparam logic [31:0] C_NOP = 32'h0000_0000;   // sll $0,$0,0

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_inst;
   logic [31:0] w_inst_nxt;
   logic [31:0] r_pc4;
   logic [31:0] w_pc4_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic        r_fault;
   logic        w_fault_nxt;

   logic [31:0] w_off;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target_aligned;
   logic        w_in_range;
   logic        w_unused_off;

   // Byte offset into program memory; wraps so PCs below the base look huge
   // and therefore fail the range check.
   assign w_off            = r_pc - PC_RESET;
   assign w_pc_plus4       = r_pc + 32'd4;
   assign w_target_aligned = {RedirectTarget[31:2], 2'b00};
   assign w_in_range       = (r_pc[1:0] == 2'b00) &&
                             ({2'b00, w_off[31:2]} < 32'(MEMORY_DEPTH));
   // Byte-lane bits of the offset only matter through r_pc[1:0] above.
   assign w_unused_off     = ^w_off[1:0];

   assign IMemAddr         = w_off[AW+1:2];

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_RUN;
         r_pc    <= PC_RESET;
         r_inst  <= C_NOP;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_inst  <= w_inst_nxt;
         r_pc4   <= w_pc4_nxt;
         r_valid <= w_valid_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Priority in RUN: Redirect > fault > Stall > advance.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_inst_nxt  = r_inst;
      w_pc4_nxt   = r_pc4;
      w_valid_nxt = r_valid;
      w_fault_nxt = r_fault;

      if (Redirect) begin
         // Redirect wins in either state and always leaves a bubble behind.
         w_state_nxt = ST_RUN;
         w_pc_nxt    = w_target_aligned;
         w_inst_nxt  = C_NOP;
         w_pc4_nxt   = 32'd0;
         w_valid_nxt = 1'b0;
         if (RedirectTarget[1:0] != 2'b00) begin
            w_fault_nxt = 1'b1;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (!w_in_range) begin
                  w_state_nxt = ST_FAULT;
                  w_fault_nxt = 1'b1;
                  w_inst_nxt  = C_NOP;
                  w_pc4_nxt   = 32'd0;
                  w_valid_nxt = 1'b0;
               end else if (!Stall) begin
                  w_pc_nxt    = w_pc_plus4;
                  w_inst_nxt  = IMemData;
                  w_pc4_nxt   = w_pc_plus4;
                  w_valid_nxt = 1'b1;
               end
            end
            ST_FAULT: begin
               // Parked: PC holds, bubbles stream out, Stall is irrelevant.
               w_inst_nxt  = C_NOP;
               w_pc4_nxt   = 32'd0;
               w_valid_nxt = 1'b0;
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   assign PC             = r_pc;
   assign ID_Instruction = r_inst;
   assign ID_PC_4        = r_pc4;
   assign ID_Valid       = r_valid;
   assign FetchFault     = r_fault;
   assign Flush          = Redirect;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage. Two instances share
//               the control inputs: one with the default 512-word memory and
//               one with a 4-word memory to exercise the end-of-memory fault.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectTarget;

   logic [8:0]  a0;
   logic [1:0]  a1;
   logic [31:0] d0, d1, pc0, pc1, in0, in1, p40, p41;
   logic        v0, v1, fl0, fl1, ff0, ff1;

   logic [31:0] mem0 [512];
   logic [31:0] mem1 [4];

   assign d0 = mem0[a0];
   assign d1 = mem1[a1];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(.MEMORY_DEPTH(512), .PC_RESET(BASE)) u_dut0 (
      .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
      .RedirectTarget(RedirectTarget), .IMemAddr(a0), .IMemData(d0),
      .PC(pc0), .ID_Instruction(in0), .ID_PC_4(p40), .ID_Valid(v0),
      .Flush(fl0), .FetchFault(ff0)
   );

   if_fetch_stage #(.MEMORY_DEPTH(4), .PC_RESET(BASE)) u_dut1 (
      .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
      .RedirectTarget(RedirectTarget), .IMemAddr(a1), .IMemData(d1),
      .PC(pc1), .ID_Instruction(in1), .ID_PC_4(p41), .ID_Valid(v1),
      .Flush(fl1), .FetchFault(ff1)
   );

   // ---------------- reference model --------------------------------------
   logic [31:0] m_pc   [2];
   logic [31:0] m_inst [2];
   logic [31:0] m_pc4  [2];
   logic        m_valid[2];
   logic        m_ff   [2];
   logic        m_parked[2];   // fetch is parked after a bad address

   function automatic int unsigned depth_of(input int k);
      return (k == 0) ? 512 : 4;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = BASE; m_inst[k] = 0; m_pc4[k] = 0;
         m_valid[k] = 0; m_ff[k] = 0; m_parked[k] = 0;
      end
   endtask

   task automatic bubble(input int k);
      m_inst[k] = 0; m_pc4[k] = 0; m_valid[k] = 0;
   endtask

   task automatic model_step();
      logic [31:0] off;
      logic [31:0] word_idx;
      bit          ok;
      for (int k = 0; k < 2; k++) begin
         off      = m_pc[k] - BASE;
         word_idx = off >> 2;
         ok       = (m_pc[k] % 4 == 0) && (word_idx < depth_of(k));
         if (Redirect) begin
            m_pc[k] = RedirectTarget & ~32'd3;
            if (RedirectTarget % 4 != 0) m_ff[k] = 1;
            m_parked[k] = 0;
            bubble(k);
         end else if (m_parked[k]) begin
            bubble(k);
         end else if (!ok) begin
            m_parked[k] = 1;
            m_ff[k] = 1;
            bubble(k);
         end else if (!Stall) begin
            m_inst[k]  = (k == 0) ? mem0[word_idx] : mem1[word_idx];
            m_pc4[k]   = m_pc[k] + 4;
            m_valid[k] = 1;
            m_pc[k]    = m_pc[k] + 4;
         end
      end
   endtask

   // ---------------- checking ---------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("pc0",    pc0, m_pc[0]);
      check("addr0",  {23'd0, a0}, ((m_pc[0] - BASE) >> 2) % 512);
      check("inst0",  in0, m_inst[0]);
      check("pc4_0",  p40, m_pc4[0]);
      check("valid0", {31'd0, v0}, {31'd0, m_valid[0]});
      check("fault0", {31'd0, ff0}, {31'd0, m_ff[0]});
      check("pc1",    pc1, m_pc[1]);
      check("addr1",  {30'd0, a1}, ((m_pc[1] - BASE) >> 2) % 4);
      check("inst1",  in1, m_inst[1]);
      check("pc4_1",  p41, m_pc4[1]);
      check("valid1", {31'd0, v1}, {31'd0, m_valid[1]});
      check("fault1", {31'd0, ff1}, {31'd0, m_ff[1]});
   endtask

   // Called on a falling edge; returns on the next falling edge.
   task automatic cycle(input logic st, input logic rd, input logic [31:0] tg);
      Stall = st; Redirect = rd; RedirectTarget = tg;
      #1;
      check("flush0", {31'd0, fl0}, {31'd0, rd});
      check("flush1", {31'd0, fl1}, {31'd0, rd});
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   // Asserts reset between edges and checks outputs before any clock edge.
   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_pc", pc0, BASE);
      check("rst_valid", {31'd0, v1}, 32'd0);
      check("rst_fault", {31'd0, ff1}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1; Stall = 0; Redirect = 0; RedirectTarget = 0;
      for (int i = 0; i < 512; i++) mem0[i] = $urandom;
      for (int i = 0; i < 4; i++)   mem1[i] = $urandom;
      mem0[0] = 32'h2008_0001;
      mem0[1] = 32'h2009_0002;
      mem0[2] = 32'h0109_5020;
      @(negedge clk);
      do_reset();

      // Free-running fetch
      for (int i = 0; i < 2; i++) begin
         check("imaddr_step", {23'd0, a0}, i);
         cycle(0, 0, 0);
         check("id_pc4_step", p40, BASE + 4 * (i + 1));
         check("id_valid_step", {31'd0, v0}, 32'd1);
      end
      // Two-cycle stall at 0x00400008
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("stall_pc", pc0, 32'h0040_0008);
      check("stall_inst", in0, 32'h2009_0002);
      cycle(0, 0, 0);
      check("post_stall_pc", pc0, 32'h0040_000C);
      check("post_stall_inst", in0, 32'h0109_5020);
      // Redirect together with Stall
      cycle(1, 1, 32'h0040_0040);
      check("redir_pc", pc0, 32'h0040_0040);
      check("redir_bubble", {31'd0, v0}, 32'd0);
      cycle(0, 0, 0);
      check("redir_target_inst", in0, mem0[16]);
      check("redir_target_valid", {31'd0, v0}, 32'd1);
      // Misaligned redirect
      cycle(0, 1, 32'h0040_0042);
      check("misalign_pc", pc0, 32'h0040_0040);
      check("misalign_fault", {31'd0, ff0}, 32'd1);
      cycle(0, 0, 0);
      check("misalign_runs", {31'd0, v0}, 32'd1);

      // End-of-memory fault on the 4-word instance
      do_reset();
      for (int i = 0; i < 6; i++) cycle(0, 0, 0);
      check("eom_pc", pc1, 32'h0040_0010);
      check("eom_fault", {31'd0, ff1}, 32'd1);
      check("eom_bubble", {31'd0, v1}, 32'd0);
      cycle(1, 0, 0);
      check("eom_stall_ignored", pc1, 32'h0040_0010);
      cycle(0, 1, BASE);
      check("eom_redir_pc", pc1, BASE);
      check("eom_sticky", {31'd0, ff1}, 32'd1);
      cycle(0, 0, 0);
      check("eom_resume", {31'd0, v1}, 32'd1);
      check("eom_resume_inst", in1, mem1[0]);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0);
      check("eom_refault", {31'd0, ff1}, 32'd1);
      do_reset();   // asynchronous reset while parked

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         logic        st, rd;
         logic [31:0] tg;
         st = ($urandom % 4) == 0;
         rd = ($urandom % 10) == 0;
         case ($urandom % 8)
            0:       tg = 32'hFFFF_FFFC;
            1:       tg = BASE + ($urandom_range(0, 7) << 2) + ($urandom % 4);
            2:       tg = BASE - 4;
            default: tg = BASE + ($urandom_range(0, 530) << 2);
         endcase
         if (($urandom % 80) == 0) do_reset();
         else cycle(st, rd, tg);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
